// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit: iterative HI/LO unit executing MULT, MULTU, DIV, DIVU, MTHI, MTLO.
// Ports: Clk/Reset (sync, active-high); Start+Op request (sampled only while idle);
//        ReadData0 = rs, ReadData1 = rt; Busy while an operation is in flight;
//        Done pulses one cycle after Hi/Lo are written by a mult/div; Hi/Lo = architectural registers.
module multiply_divide_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] ReadData0,
    input  logic [WIDTH-1:0] ReadData1,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               sgn0, sgn1;
    logic [WIDTH-1:0]   abs0, abs1;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               div0;
    assign Busy = state != IDLE;
    always_comb begin
        sgn0 = ~Op[0] & ReadData0[WIDTH-1];
        sgn1 = ~Op[0] & ReadData1[WIDTH-1];
        abs0 = sgn0 ? -ReadData0 : ReadData0;
        abs1 = sgn1 ? -ReadData1 : ReadData1;
        // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        // divide: acc = {remainder, dividend bits becoming quotient bits}, shifted left each step
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd};
        div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        // with a zero divisor the remainder ends up as |dividend|, so re-signing restores rs
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        div0     = opnd == {WIDTH{1'b0}};
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Hi    <= '0;
            Lo    <= '0;
            Done  <= 1'b0;
            count <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    if (!Op[2]) begin
                        state  <= RUN;
                        is_div <= Op[1];
                        neg_q  <= sgn0 ^ sgn1;
                        neg_r  <= sgn0;
                        count  <= '0;
                        opnd   <= Op[1] ? abs1 : abs0;
                        acc    <= {{WIDTH{1'b0}}, Op[1] ? abs0 : abs1};
                    end else if (Op[1:0] == 2'b00) begin
                        Hi <= ReadData0;
                    end else if (Op[1:0] == 2'b01) begin
                        Lo <= ReadData0;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    Hi    <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    Lo    <= is_div ? (div0 ? {WIDTH{1'b1}} : q_fix) : prod_fix[WIDTH-1:0];
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiply_divide_unit.sv
// tb_multiply_divide_unit: self-checking bench for multiply_divide_unit against an arithmetic model.
module tb_multiply_divide_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'b0;
    logic [31:0] ReadData0 = '0;
    logic [31:0] ReadData1 = '0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;
    int tests = 0;
    int fails = 0;
    logic [31:0] hm = '0;
    logic [31:0] lm = '0;

    multiply_divide_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .ReadData0(ReadData0), .ReadData1(ReadData1),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                           input logic [63:0] cur);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'b0, a};
        longint ub = {32'b0, b};
        longint q, r;
        logic [63:0] p;
        case (op)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
            3'd2, 3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = (op == 3'd2) ? sa / sb : ua / ub;
                r = (op == 3'd2) ? sa % sb : ua % ub;
                return {r[31:0], q[31:0]};
            end
            3'd4: return {a, cur[31:0]};
            3'd5: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Drives one request at the current negedge and waits (bounded) for Busy to drop.
    // poke>0 injects an MTLO 0x55 request on that busy cycle; operands are scrambled while busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input int poke,
                         output int busy_n, output int done_early, output int changed,
                         output logic done_ok);
        logic [31:0] h0, l0;
        h0 = Hi; l0 = Lo;
        Start = 1'b1; Op = op; ReadData0 = a; ReadData1 = b;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        busy_n = 0; done_early = 0; changed = 0;
        while (Busy && busy_n < 100) begin
            busy_n++;
            if (Done) done_early++;
            if (Hi !== h0 || Lo !== l0) changed++;
            ReadData0 = $urandom; ReadData1 = $urandom;
            if (busy_n == poke) begin
                Start = 1'b1; Op = 3'b101; ReadData0 = 32'h55;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        done_ok = Done;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", Done); end
        tests++; if (Hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", Hi); end
        tests++; if (Lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", Lo); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_directed;
        logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2};
        logic [31:0] av  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100,
                                 32'hFFFFFFF9, 32'h80000000, 32'h1234, 32'hFFFFFFF8};
        logic [31:0] bv  [8] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7,
                                 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] eh  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'd2,
                                 32'hFFFFFFFF, 32'h0, 32'h1234, 32'hFFFFFFF8};
        logic [31:0] el  [8] = '{32'hFFFFFFF1, 32'h1, 32'h1, 32'd14,
                                 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int bn, de, ch;
        logic dk;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], av[i], bv[i], 0, bn, de, ch, dk);
            hm = eh[i]; lm = el[i];
            tests++; if (bn != 33) begin fails++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, bn); end
            tests++; if (dk !== 1'b1) begin fails++; $display("FAIL dir%0d_done got %b want 1", i, dk); end
            tests++; if (de != 0) begin fails++; $display("FAIL dir%0d_early_done got %0d want 0", i, de); end
            tests++; if (ch != 0) begin fails++; $display("FAIL dir%0d_hilo_during_run got %0d changes want 0", i, ch); end
            tests++; if (Hi !== eh[i]) begin fails++; $display("FAIL dir%0d_hi got %h want %h", i, Hi, eh[i]); end
            tests++; if (Lo !== el[i]) begin fails++; $display("FAIL dir%0d_lo got %h want %h", i, Lo, el[i]); end
        end
        @(negedge Clk);
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL done_width got %b want 0", Done); end
    endtask

    task automatic test_random;
        int bn, de, ch;
        logic dk;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            e = ref_op(op, a, b, {hm, lm});
            issue(op, a, b, 0, bn, de, ch, dk);
            hm = e[63:32]; lm = e[31:0];
            tests++; if (bn != 33 || dk !== 1'b1) begin fails++; $display("FAIL rnd%0d_timing busy %0d done %b want 33/1", i, bn, dk); end
            tests++; if ({Hi, Lo} !== e) begin fails++; $display("FAIL rnd%0d op%0d %h,%h got %h_%h want %h_%h", i, op, a, b, Hi, Lo, e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_mthi_mtlo;
        int bn, de, ch;
        logic dk;
        logic [63:0] e;
        Start = 1'b1; Op = 3'b100; ReadData0 = 32'hA5A5A5A5;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        hm = 32'hA5A5A5A5;
        tests++; if (Hi !== hm || Lo !== lm) begin fails++; $display("FAIL mthi got %h_%h want %h_%h", Hi, Lo, hm, lm); end
        tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin fails++; $display("FAIL mthi_flags busy %b done %b want 0/0", Busy, Done); end
        Start = 1'b1; Op = 3'b101; ReadData0 = 32'h0BADF00D;
        @(posedge Clk); @(negedge Clk);
        lm = 32'h0BADF00D;
        Start = 1'b1; Op = 3'b110; ReadData0 = 32'h12345678; ReadData1 = 32'h9;
        @(posedge Clk); @(negedge Clk);
        Op = 3'b111;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        tests++; if (Hi !== hm || Lo !== lm) begin fails++; $display("FAIL mtlo_undef got %h_%h want %h_%h", Hi, Lo, hm, lm); end
        tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin fails++; $display("FAIL undef_flags busy %b done %b want 0/0", Busy, Done); end
        e = ref_op(3'd0, 32'h00012345, 32'hFFFF0001, {hm, lm});
        issue(3'd0, 32'h00012345, 32'hFFFF0001, 5, bn, de, ch, dk);
        hm = e[63:32]; lm = e[31:0];
        tests++; if ({Hi, Lo} !== e) begin fails++; $display("FAIL mtlo_during_run got %h_%h want %h_%h", Hi, Lo, e[63:32], e[31:0]); end
        tests++; if (bn != 33 || ch != 0) begin fails++; $display("FAIL mtlo_during_run_timing busy %0d changes %0d want 33/0", bn, ch); end
    endtask

    task automatic test_reset_mid;
        int bn, de, ch, seen;
        logic dk;
        Start = 1'b1; Op = 3'b011; ReadData0 = 32'd100; ReadData1 = 32'd7;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        hm = '0; lm = '0;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", Busy); end
        tests++; if (Hi !== 32'h0 || Lo !== 32'h0) begin fails++; $display("FAIL midreset_hilo got %h_%h want 0_0", Hi, Lo); end
        seen = 0;
        repeat (40) begin
            if (Done !== 1'b0 || Busy !== 1'b0) seen++;
            @(negedge Clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midreset_activity got %0d active cycles want 0", seen); end
        issue(3'd1, 32'd6, 32'd7, 0, bn, de, ch, dk);
        hm = 32'd0; lm = 32'd42;
        tests++; if (Hi !== hm || Lo !== lm) begin fails++; $display("FAIL after_reset_multu got %h_%h want 0_2a", Hi, Lo); end
        tests++; if (bn != 33 || dk !== 1'b1) begin fails++; $display("FAIL after_reset_timing busy %0d done %b want 33/1", bn, dk); end
    endtask

    task automatic test_back_to_back;
        int bn, de, ch;
        logic dk;
        logic [63:0] e;
        e = ref_op(3'd2, 32'hFFFFFF00, 32'd3, {hm, lm});
        issue(3'd2, 32'hFFFFFF00, 32'd3, 0, bn, de, ch, dk);
        hm = e[63:32]; lm = e[31:0];
        tests++; if ({Hi, Lo} !== e || dk !== 1'b1) begin fails++; $display("FAIL b2b_first got %h_%h done %b want %h_%h", Hi, Lo, dk, e[63:32], e[31:0]); end
        e = ref_op(3'd0, 32'h7FFFFFFF, 32'h80000000, {hm, lm});
        issue(3'd0, 32'h7FFFFFFF, 32'h80000000, 0, bn, de, ch, dk);
        hm = e[63:32]; lm = e[31:0];
        tests++; if ({Hi, Lo} !== e) begin fails++; $display("FAIL b2b_second got %h_%h want %h_%h", Hi, Lo, e[63:32], e[31:0]); end
        tests++; if (bn != 33 || de != 0) begin fails++; $display("FAIL b2b_second_timing busy %0d early %0d want 33/0", bn, de); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_mthi_mtlo;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multiply_divide_unit.md
Name: multiply_divide_unit

Overview:
- Iterative HI/LO unit for the MIPS core; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the single-cycle ALU in EX and consumes the same operand pair (rs in ReadData0, rt in ReadData1).
- Holds the architectural Hi/Lo registers.
- Provides a Start/Busy/Done handshake so the pipeline stalls MFHI/MFLO and any new mult/div until the result is written.

Parameters:
WIDTH, 32, operand width; an operation takes WIDTH iteration cycles.

Ports:
Clk  input  1  clock; all state updates on its rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only while Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others no-op
ReadData0  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
ReadData1  input  WIDTH  rt operand (multiplier / divisor)
Busy  output  1  high while an operation is in flight (state != IDLE)
Done  output  1  one-cycle pulse: Hi/Lo were just updated by MULT/DIV
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, Hi=0, Lo=0, Done=0, Busy=0, iteration counter=0. Reset wins over all other inputs, including mid-operation; any partial result is discarded.
- States: IDLE, RUN, FIX. Busy = (state != IDLE), decoded combinationally from state.
- IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU: on the next edge, latch magnitudes and op, set sign flags, clear the accumulator, set count=0, go to RUN.
  - Signed ops use |operand| and record signs.
  - Unsigned ops use operands as-is.
- IDLE, Start=1, Op=MTHI/MTLO: on the next edge, Hi (or Lo) <= ReadData0. State stays IDLE, Busy stays 0, Done stays 0.
- IDLE, Start=1, Op undefined: no effect.
- RUN: one radix-2 step per cycle, WIDTH cycles (count 0..WIDTH-1); after the last step go to FIX.
  - Multiply: shift-add over a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract; a quotient bit is 1 when the trial remainder is >= 0.
- FIX: one cycle. Apply sign correction, write Hi/Lo, assert Done on the following cycle, return to IDLE.
  - Signed multiply: negate the 2*WIDTH-bit product if the operand signs differ.
  - Signed quotient: negated if the signs differ (truncates toward zero).
  - Signed remainder: takes the sign of the dividend.
  - MULT*: Hi = product[2W-1:W], Lo = product[W-1:0].
  - DIV*: Lo = quotient, Hi = remainder.
- Latency: Start sampled at edge 0. Busy is high from edge 0 through edge WIDTH+1, which is 33 cycles for WIDTH=32. Hi/Lo change at edge WIDTH+1. Done is high for exactly the cycle after that edge, with Busy already 0.
- Hi/Lo hold their previous values throughout RUN; no partial results are visible.
- Start while Busy=1 is ignored for every Op, including MTHI/MTLO; the pipeline must hold the request.
- Start in the same cycle Done is high: accepted normally (Busy=0 there), giving back-to-back operation.
- Divide by zero (DIV or DIVU): Lo = all-ones, Hi = original ReadData0. Done and latency are unchanged, and no exception is raised.
- DIV of -2^(W-1) by -1: Lo = 0x80000000, Hi = 0. There is no trap.
- Operands are captured at Start. Changes to ReadData0/ReadData1 during RUN have no effect.

Test Plan:
- MULT 0xFFFFFFFD (-3) x 5 -> Busy high 33 cycles, then Done pulse; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then MULT on the same values -> Hi=0, Lo=1.
- DIVU 100 / 7 -> Lo=14, Hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 0x1234 / 0 -> after 33 busy cycles, Lo=0xFFFFFFFF, Hi=0x1234, Done pulses once.
- MTHI 0xA5A5A5A5 at idle -> Hi updates next edge, Busy and Done stay 0. Then start MULT and, mid-RUN, request MTLO 0x55 -> MTLO ignored; after Done, Lo = product low word.
- Start DIVU 100/7, assert Reset at cycle 10 -> next edge Busy=0, Hi=Lo=0, no Done. A new MULTU 6 x 7 completes with Lo=42, Hi=0.
